blitter_write_buffer: RTL and testbench
=======================================

Name: blitter_write_buffer

Overview:
Write-combining buffer between the blitter pixel pipeline's byte-write port and the SDRAM burst-write port. It collects byte writes that fall in one 32-byte aligned line into an 8x32-bit line buffer with a 32-bit byte mask. It flushes the line as an 8-beat masked burst when a write targets a different line, when the line is fully written, or when a flush is requested. It is the write-side counterpart of the blitter read cache.

Parameters:
TIMEOUT_CYCLES, 64, idle cycles in FILL before an automatic flush (used only with BLIT_WB_TIMEOUT_EN).

Ports:
clock  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
write_address  input  26  blitter byte address
write_data  input  8  byte to write
write_request  input  1  blitter write strobe
write_stall  output  1  combinational; write not accepted this cycle, blitter holds request
flush  input  1  single-cycle pulse; push dirty line to memory (end of blit)
idle  output  1  high when buffer clean and no burst in flight
mem_address  output  26  burst base address {tag,5'b0}
mem_request  output  1  burst write request, held until mem_ack
mem_wdata  output  32  current beat data
mem_wmask  output  4  current beat byte enables (bit n = bits 8n+7:8n)
mem_data_req  input  1  memory consumes current beat this cycle
mem_ack  input  1  request accepted
mem_complete  input  1  burst finished

Behaviour:
- Reset values: mem_request=0, mem_address=0, state=IDLE, mask=0, beat pointer=0, idle=1, write_stall=0. Line data contents are don't-care.
- States: IDLE (clean), FILL (dirty, tag valid), FLUSH_REQ (mem_request high), FLUSH_DATA (streaming beats), FLUSH_WAIT (waiting for mem_complete).
- Accept condition: write_request && (state==IDLE || (state==FILL && write_address[25:5]==tag)).
- write_stall = write_request && !accept.
- On accept:
  - byte goes to data[addr[4:2]] lane addr[1:0];
  - mask[addr[4:0]] is set;
  - in IDLE, tag <= addr[25:5] and state -> FILL.
  - A repeated write to the same byte overwrites it (last write wins).
- FILL -> FLUSH_REQ when any of these hold:
  - a write_request misses the tag (stalled, not accepted);
  - flush=1;
  - the accepted write makes the mask all ones.
- Flush in the same cycle as an accepted write: the byte is included, then FLUSH_REQ.
- Flush in IDLE with no write: ignored.
- Entering FLUSH_REQ:
  - mem_address <= {tag,5'b0}, mem_request <= 1, beat pointer <= 0.
  - FLUSH_REQ -> FLUSH_DATA on mem_ack; mem_request <= 0 on the same edge.
- FLUSH_DATA:
  - mem_wdata = data[ptr] and mem_wmask = mask[4*ptr+3:4*ptr], combinationally from the pointer.
  - Each mem_data_req cycle advances ptr.
  - After the 8th beat (ptr 7 consumed) -> FLUSH_WAIT. Extra mem_data_req cycles are ignored.
- FLUSH_WAIT -> IDLE on mem_complete; mask cleared.
- mem_complete seen in FLUSH_DATA also forces IDLE, with mask cleared.
- A stalled miss is accepted in the first IDLE cycle, so latency is one cycle after mem_complete.
- All-zero beats are still sent with mask 0; the burst is always 8 beats.
- idle = (state==IDLE).
- Latency: an accepted write is visible in memory no earlier than mem_complete of the next flush.
- Reset mid-burst: immediate return to reset state; buffered data is discarded; mem_request drops the next edge.

Optional Feature:
Macro BLIT_WB_TIMEOUT_EN.
- Defined: a counter clears on every accepted write and increments each cycle in FILL. Reaching TIMEOUT_CYCLES-1 forces FILL -> FLUSH_REQ as if flush were pulsed. The counter is 0 outside FILL.
- Undefined: no counter; a dirty line stays in FILL until a miss, a full mask, or flush.

Test Plan:
1. Reset, then write 0xAA@0x000040 and 0xBB@0x000047, then pulse flush. Required: mem_address=0x000040. Beat0 wdata[7:0]=0xAA, mask=0001. Beat1 wdata[31:24]=0xBB, mask=1000. Beats 2-7 mask=0000. idle=1 after mem_complete.
2. Write 32 sequential bytes 0x00..0x1F to 0x000100. Required: auto flush after the 32nd write with all beats mask=1111, beat0 wdata=0x03020100, beat7 wdata=0x1F1E1D1C, and no stall during fill.
3. Write @0x000020, then request @0x000060. Required:
   - write_stall=1 from the miss cycle until the cycle after mem_complete.
   - Flush address 0x000020.
   - The new write is then accepted with tag 0x000060>>5.
4. Hold mem_ack low for 10 cycles, then gap mem_data_req (beats on alternate cycles). Required: mem_request held until mem_ack; wdata/wmask stable between beats; exactly 8 beats consumed.
5. Assert reset during FLUSH_DATA beat 3. Required: next cycle mem_request=0, idle=1, and a subsequent flush pulse in IDLE produces no mem_request.
6. (BLIT_WB_TIMEOUT_EN, TIMEOUT_CYCLES=64) Write one byte, then stay idle. Required: mem_request rises 64 cycles after the write. Undefined build: no mem_request after 200 cycles.

Source files
------------

// File: rtl/blitter_write_buffer.sv
// Write-combining buffer: gathers blitter byte writes into one 32-byte line and flushes it as an 8-beat masked SDRAM burst.
// Optional idle-timeout flush is built in when BLIT_WB_TIMEOUT_EN is defined.
module blitter_write_buffer #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [25:0] write_address,
   input  logic [7:0]  write_data,
   input  logic        write_request,
   output logic        write_stall,
   input  logic        flush,
   output logic        idle,
   output logic [25:0] mem_address,
   output logic        mem_request,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_data_req,
   input  logic        mem_ack,
   input  logic        mem_complete
);

   // state      | meaning
   // IDLE       | line clean, tag invalid
   // FILL       | line dirty, tag valid, collecting bytes
   // FLUSH_REQ  | burst requested, waiting for mem_ack
   // FLUSH_DATA | streaming 8 beats on mem_data_req
   // FLUSH_WAIT | all beats sent, waiting for mem_complete
   localparam logic [2:0] S_IDLE       = 3'd0;
   localparam logic [2:0] S_FILL       = 3'd1;
   localparam logic [2:0] S_FLUSH_REQ  = 3'd2;
   localparam logic [2:0] S_FLUSH_DATA = 3'd3;
   localparam logic [2:0] S_FLUSH_WAIT = 3'd4;

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 2");
   end

   logic [2:0]  r_state;
   logic [20:0] r_tag;
   logic [31:0] r_mask;
   logic [2:0]  r_ptr;
   logic [31:0] r_data [8];
   logic [25:0] r_mem_address;
   logic        r_mem_request;

   logic        w_hit;
   logic        w_accept;
   logic [31:0] w_mask_next;
   logic [20:0] w_tag_next;
   logic        w_timeout;
   logic        w_start_flush;

   assign w_hit       = (write_address[25:5] == r_tag);
   assign w_accept    = write_request && ((r_state == S_IDLE) || ((r_state == S_FILL) && w_hit));
   assign write_stall = write_request && !w_accept;
   assign w_mask_next = w_accept ? (r_mask | (32'd1 << write_address[4:0])) : r_mask;
   assign w_tag_next  = (r_state == S_IDLE) ? write_address[25:5] : r_tag;

   // A write accepted together with flush is folded into the line before the burst starts.
   assign w_start_flush = ((r_state == S_FILL) &&
                           (write_stall || flush || w_timeout || (w_accept && (&w_mask_next)))) ||
                          ((r_state == S_IDLE) && w_accept && flush);

`ifdef BLIT_WB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CW-1:0] r_idle_cnt;

   always_ff @(posedge clock) begin
      if (reset || w_accept || (r_state != S_FILL)) r_idle_cnt <= '0;
      else                                          r_idle_cnt <= r_idle_cnt + 1'b1;
   end

   assign w_timeout = (r_state == S_FILL) && (r_idle_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
   assign w_timeout = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_tag         <= '0;
         r_mask        <= '0;
         r_ptr         <= '0;
         r_mem_address <= '0;
         r_mem_request <= 1'b0;
      end else begin
         if (w_accept) begin
            r_mask <= w_mask_next;
            r_tag  <= w_tag_next;
         end
         if (w_start_flush) begin
            r_state       <= S_FLUSH_REQ;
            r_mem_address <= {w_tag_next, 5'b0};
            r_mem_request <= 1'b1;
            r_ptr         <= '0;
         end else begin
            case (r_state)
               S_IDLE: if (w_accept) r_state <= S_FILL;
               S_FILL: ;
               S_FLUSH_REQ: begin
                  if (mem_ack) begin
                     r_state       <= S_FLUSH_DATA;
                     r_mem_request <= 1'b0;
                  end
               end
               S_FLUSH_DATA: begin
                  if (mem_complete) begin
                     r_state <= S_IDLE;
                     r_mask  <= '0;
                     r_ptr   <= '0;
                  end else if (mem_data_req) begin
                     if (r_ptr == 3'd7) r_state <= S_FLUSH_WAIT;
                     else               r_ptr   <= r_ptr + 3'd1;
                  end
               end
               S_FLUSH_WAIT: begin
                  if (mem_complete) begin
                     r_state <= S_IDLE;
                     r_mask  <= '0;
                     r_ptr   <= '0;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   // Line data needs no reset; the mask decides which bytes reach memory.
   always_ff @(posedge clock) begin
      if (w_accept) r_data[write_address[4:2]][{write_address[1:0], 3'b000} +: 8] <= write_data;
   end

   assign idle        = (r_state == S_IDLE);
   assign mem_address = r_mem_address;
   assign mem_request = r_mem_request;
   assign mem_wdata   = r_data[r_ptr];
   assign mem_wmask   = r_mask[{r_ptr, 2'b00} +: 4];

endmodule

// File: tb/tb_blitter_write_buffer.sv
// Directed self-checking bench for blitter_write_buffer; define BLIT_WB_TIMEOUT_EN here too to check the timeout build.
module tb_blitter_write_buffer;

   logic        clock = 1'b0;
   logic        reset;
   logic [25:0] write_address;
   logic [7:0]  write_data;
   logic        write_request;
   logic        write_stall;
   logic        flush;
   logic        idle;
   logic [25:0] mem_address;
   logic        mem_request;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_data_req;
   logic        mem_ack;
   logic        mem_complete;

   int checks = 0;
   int errors = 0;
   logic [31:0] cap_d [8];
   logic [3:0]  cap_m [8];

   blitter_write_buffer #(.TIMEOUT_CYCLES(64)) dut (
      .clock(clock), .reset(reset),
      .write_address(write_address), .write_data(write_data),
      .write_request(write_request), .write_stall(write_stall),
      .flush(flush), .idle(idle),
      .mem_address(mem_address), .mem_request(mem_request),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_data_req(mem_data_req), .mem_ack(mem_ack), .mem_complete(mem_complete)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [25:0] a, input logic [7:0] d);
      write_address = a;
      write_data    = d;
      write_request = 1'b1;
      #1 chk("wr_no_stall", {31'd0, write_stall}, 32'd0);
      tick();
      write_request = 1'b0;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // Memory side: optional ack delay, optional idle cycle before every beat, then completion.
   task automatic burst(input int ack_delay, input bit gap);
      int n = 0;
      logic [31:0] pre_d;
      logic [3:0]  pre_m;
      while (!mem_request && n < 50) begin
         tick();
         n++;
      end
      chk("req_rise", {31'd0, mem_request}, 32'd1);
      for (int i = 0; i < ack_delay; i++) begin
         chk("req_held", {31'd0, mem_request}, 32'd1);
         chk("stall_in_flush", {31'd0, write_stall}, {31'd0, write_request});
         tick();
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      chk("req_drop_on_ack", {31'd0, mem_request}, 32'd0);
      for (int b = 0; b < 8; b++) begin
         if (gap) begin
            pre_d = mem_wdata;
            pre_m = mem_wmask;
            tick();
            chk("wdata_stable", mem_wdata, pre_d);
            chk("wmask_stable", {28'd0, mem_wmask}, {28'd0, pre_m});
         end
         cap_d[b] = mem_wdata;
         cap_m[b] = mem_wmask;
         mem_data_req = 1'b1;
         tick();
         mem_data_req = 1'b0;
      end
      mem_data_req = 1'b1;
      tick();
      mem_data_req = 1'b0;
      chk("extra_beat_ignored", mem_wdata, cap_d[7]);
      chk("busy_before_complete", {31'd0, idle}, 32'd0);
      chk("stall_before_complete", {31'd0, write_stall}, {31'd0, write_request});
      mem_complete = 1'b1;
      tick();
      mem_complete = 1'b0;
      chk("idle_after_complete", {31'd0, idle}, 32'd1);
   endtask

   initial begin
      bit seen;
      reset = 1'b1; write_address = '0; write_data = '0; write_request = 1'b0;
      flush = 1'b0; mem_data_req = 1'b0; mem_ack = 1'b0; mem_complete = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_idle", {31'd0, idle}, 32'd1);
      chk("rst_req", {31'd0, mem_request}, 32'd0);
      chk("rst_addr", {6'd0, mem_address}, 32'd0);
      chk("rst_stall", {31'd0, write_stall}, 32'd0);

      // two sparse bytes then explicit flush
      wr(26'h000040, 8'hAA);
      wr(26'h000047, 8'hBB);
      chk("t1_not_idle", {31'd0, idle}, 32'd0);
      pulse_flush();
      chk("t1_addr", {6'd0, mem_address}, 32'h40);
      burst(0, 1'b0);
      chk("t1_b0_data", {24'd0, cap_d[0][7:0]}, 32'hAA);
      chk("t1_b0_mask", {28'd0, cap_m[0]}, 32'h1);
      chk("t1_b1_data", {24'd0, cap_d[1][31:24]}, 32'hBB);
      chk("t1_b1_mask", {28'd0, cap_m[1]}, 32'h8);
      for (int b = 2; b < 8; b++) chk("t1_bx_mask", {28'd0, cap_m[b]}, 32'h0);

      // full line auto-flush
      for (int i = 0; i < 32; i++) begin
         wr(26'h000100 + 26'(i), 8'(i));
         if (i == 30) chk("t2_no_early_req", {31'd0, mem_request}, 32'd0);
      end
      chk("t2_auto_req", {31'd0, mem_request}, 32'd1);
      chk("t2_addr", {6'd0, mem_address}, 32'h100);
      burst(0, 1'b0);
      for (int b = 0; b < 8; b++) chk("t2_mask", {28'd0, cap_m[b]}, 32'hF);
      chk("t2_b0_data", cap_d[0], 32'h03020100);
      chk("t2_b7_data", cap_d[7], 32'h1F1E1D1C);

      // miss stalls across the whole flush, then lands in a fresh line
      wr(26'h000020, 8'h11);
      write_address = 26'h000060;
      write_data    = 8'h22;
      write_request = 1'b1;
      #1 chk("t3_miss_stall", {31'd0, write_stall}, 32'd1);
      tick();
      chk("t3_stall_req", {31'd0, write_stall}, 32'd1);
      chk("t3_addr", {6'd0, mem_address}, 32'h20);
      burst(0, 1'b0);
      chk("t3_b0_mask", {28'd0, cap_m[0]}, 32'h1);
      chk("t3_accept_after_complete", {31'd0, write_stall}, 32'd0);
      tick();
      write_request = 1'b0;
      chk("t3_fill", {31'd0, idle}, 32'd0);
      pulse_flush();
      chk("t3_new_tag_addr", {6'd0, mem_address}, 32'h60);

      // slow ack and gapped beats on the new line's flush
      burst(10, 1'b1);
      chk("t4_b0_data", {24'd0, cap_d[0][7:0]}, 32'h22);
      chk("t4_b0_mask", {28'd0, cap_m[0]}, 32'h1);
      chk("t4_b7_mask", {28'd0, cap_m[7]}, 32'h0);

      // reset in the middle of the data phase
      wr(26'h000080, 8'h55);
      pulse_flush();
      chk("t5_req", {31'd0, mem_request}, 32'd1);
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      mem_data_req = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      mem_data_req = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t5_req_after_rst", {31'd0, mem_request}, 32'd0);
      chk("t5_idle_after_rst", {31'd0, idle}, 32'd1);
      pulse_flush();
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (mem_request) seen = 1'b1;
         tick();
      end
      chk("t5_flush_in_idle", {31'd0, seen}, 32'd0);
      chk("t5_still_idle", {31'd0, idle}, 32'd1);

      // idle-timeout behaviour
      wr(26'h000200, 8'h77);
`ifdef BLIT_WB_TIMEOUT_EN
      seen = 1'b0;
      for (int k = 1; k < 64; k++) begin
         tick();
         if (mem_request) seen = 1'b1;
      end
      chk("t6_no_early_timeout", {31'd0, seen}, 32'd0);
      tick();
      chk("t6_timeout_req", {31'd0, mem_request}, 32'd1);
      chk("t6_addr", {6'd0, mem_address}, 32'h200);
      burst(0, 1'b0);
`else
      seen = 1'b0;
      for (int k = 0; k < 200; k++) begin
         tick();
         if (mem_request) seen = 1'b1;
      end
      chk("t6_no_timeout", {31'd0, seen}, 32'd0);
      chk("t6_still_fill", {31'd0, idle}, 32'd0);
      pulse_flush();
      burst(0, 1'b0);
`endif
      chk("t6_b0_data", {24'd0, cap_d[0][7:0]}, 32'h77);
      chk("t6_b0_mask", {28'd0, cap_m[0]}, 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
